way_fill_controller: RTL and testbench
======================================

Name: way_fill_controller

Overview:
- Write-side counterpart to the way tag-compare lookup. Accepts a miss (tag) and chooses a victim way.
- Fetches the block from memory over a request/response interface, streams the data beats into the victim way, then commits the tag and valid bit.
- Sits between the cache lookup stage and the memory-side port. Handles one fill at a time in a single-set, fully-associative arrangement.

Parameters:
- NUM_WAYS, 4, number of ways (power of 2, >=2)
- ADDRESS_WIDTH, 32, byte address width
- BLOCK_SIZE, 32, block size in bytes (power of 2)
- DATA_WIDTH, 32, memory response beat width in bits; BLOCK_SIZE*8 must be a multiple of it
- Derived, not overridable: OFFSET_BITS=$clog2(BLOCK_SIZE); TAG_WIDTH=ADDRESS_WIDTH-OFFSET_BITS; BEATS=BLOCK_SIZE*8/DATA_WIDTH; BEAT_W=max(1,$clog2(BEATS)); WAY_W=$clog2(NUM_WAYS)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- miss_valid  in  1  lookup reports a miss to be filled
- miss_ready  out  1  controller accepts the miss (high only in IDLE, no flush)
- miss_tag  in  TAG_WIDTH  tag of the missing block
- way_valid  in  NUM_WAYS  current valid bit of each way
- flush  in  1  invalidate all ways
- mem_req_valid  out  1  block read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDRESS_WIDTH  {tag, OFFSET_BITS'0}
- mem_rsp_valid  in  1  response beat valid (no backpressure)
- mem_rsp_data  in  DATA_WIDTH  beat data
- mem_rsp_last  in  1  final beat marker
- way_inval  out  NUM_WAYS  clear valid of flagged ways this cycle
- way_wr_en  out  NUM_WAYS  one-hot data write strobe
- way_wr_beat  out  BEAT_W  beat index within block
- way_wr_data  out  DATA_WIDTH  beat data
- way_tag_wr  out  NUM_WAYS  one-hot tag write that also sets valid
- way_tag  out  TAG_WIDTH  tag to write
- fill_done  out  1  one-cycle pulse, fill committed
- fill_way  out  NUM_WAYS  one-hot way filled (valid with fill_done/fill_error)
- fill_error  out  1  one-cycle pulse, protocol error, fill aborted

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0, rr pointer 0. Reset mid-fill aborts with no tag write. Outstanding memory beats after reset are the memory side's responsibility.
- FSM states: IDLE, REQ, FILL, COMMIT.
- IDLE:
  - miss_ready=1 unless flush=1. If flush and miss_valid are both high, flush wins.
  - flush: way_inval=all ones for that cycle, rr pointer <= 0, stay in IDLE.
  - miss_valid&miss_ready: latch tag, choose victim, go to REQ. way_inval[victim]=1 in that same cycle, so a partially filled way never hits.
- Victim selection: lowest-index way with way_valid=0. If all ways are valid, use the rr pointer. The rr pointer increments, mod NUM_WAYS, only on a COMMIT that used it.
- REQ: mem_req_valid=1, mem_req_addr stable until mem_req_ready. On handshake go to FILL with beat counter 0.
- FILL: each mem_rsp_valid beat gives way_wr_en=victim, way_wr_beat=counter, way_wr_data=mem_rsp_data in the same cycle (combinational pass-through, zero latency), then counter++.
  - Beat BEATS-1 with last=1: go to COMMIT.
  - last=1 before beat BEATS-1, or last=0 on beat BEATS-1: the beat is still written. Pulse fill_error with fill_way=victim, no tag write, go to IDLE. The way stays invalid.
- COMMIT (one cycle): way_tag_wr=victim, way_tag=latched tag, fill_done=1, fill_way=victim, then IDLE.
- flush outside IDLE is ignored; the requester must hold it. miss_valid outside IDLE sees miss_ready=0.
- Latency, no stalls: accept -> req (1 cycle) -> BEATS beats -> commit. fill_done occurs 1 cycle after the last beat.

Decomposition:
- Package way_fill_pkg:
  - state enum (IDLE, REQ, FILL, COMMIT)
  - functions for derived widths
  - function onehot_lowest_zero(NUM_WAYS vector) -> one-hot + found flag
- One sub-module: victim_select, combinational lowest-invalid pick, with the rr pointer register and advance input inside.

Test Plan:
- All invalid, miss tag 0x1234, 8 good beats: way_inval=0001, req addr=0x0002_4680, wr beats 0..7 to way 0, COMMIT way_tag_wr=0001, fill_done.
- way_valid=1111, three back-to-back fills: victims 0001, 0010, 0100; rr advances each time.
- way_valid=1011, rr=2: victim 0100 (the invalid way), rr stays 2.
- mem_rsp_last on beat 5: beats 0..5 written, fill_error=1, fill_way=victim, no way_tag_wr, back to IDLE with miss_ready=1.
- flush and miss_valid asserted together in IDLE: way_inval=1111, miss_ready=0, rr=0. The held miss is accepted next cycle.
- reset asserted during FILL beat 3: outputs 0 asynchronously, IDLE after release, no tag write. mem_req_ready held low 10 cycles: addr stable, no beats written.

Source files
------------

// File: rtl/way_fill_pkg.sv
// Shared types and helpers for the way fill controller: FSM states,
// derived-width functions and the lowest-invalid-way picker.
package way_fill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        COMMIT
    } state_t;

    // Widest way vector the picker handles; wider caches need a larger value.
    localparam int MAX_WAYS = 64;

    typedef struct packed {
        logic                found;
        logic [MAX_WAYS-1:0] onehot;
    } pick_t;

    function automatic int calc_offset_bits(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic int calc_beats(input int block_size, input int data_width);
        return (block_size * 8) / data_width;
    endfunction

    function automatic int calc_beat_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic pick_t onehot_lowest_zero(input logic [MAX_WAYS-1:0] valid,
                                                 input int num_ways);
        pick_t r;
        r = '0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (i < num_ways && !valid[i] && !r.found) begin
                r.found     = 1'b1;
                r.onehot[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/way_fill_controller_victim_select.sv
// Victim way choice: lowest invalid way, otherwise the round-robin pointer.
// The pointer only moves when a commit actually consumed it.
module victim_select
    import way_fill_pkg::*;
#(
    parameter int NUM_WAYS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_WAYS-1:0] way_valid_i,
    input  logic                advance_i,
    input  logic                clear_i,
    output logic [NUM_WAYS-1:0] victim_o,
    output logic                use_rr_o
);

    localparam int WAY_W = $clog2(NUM_WAYS);

    logic [WAY_W-1:0] rr_q, rr_d;
    pick_t            pick;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pick     = onehot_lowest_zero(MAX_WAYS'(way_valid_i), NUM_WAYS);
        use_rr_o = !pick.found;
        victim_o = pick.found ? pick.onehot[NUM_WAYS-1:0] : (NUM_WAYS'(1) << rr_q);
        rr_d     = rr_q;
        if (clear_i) begin
            rr_d = '0;
        end else if (advance_i) begin
            rr_d = rr_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    if (NUM_WAYS < MAX_WAYS) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^pick.onehot[MAX_WAYS-1:NUM_WAYS];
    end

endmodule

// File: rtl/way_fill_controller.sv
// Fills one victim way from memory after a miss, then commits tag and valid.
// Beats pass straight through to the way data write port.
module way_fill_controller
    import way_fill_pkg::*;
#(
    parameter int NUM_WAYS      = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            miss_valid,
    output logic                                            miss_ready,
    input  logic [ADDRESS_WIDTH-calc_offset_bits(BLOCK_SIZE)-1:0] miss_tag,
    input  logic [NUM_WAYS-1:0]                             way_valid,
    input  logic                                            flush,
    output logic                                            mem_req_valid,
    input  logic                                            mem_req_ready,
    output logic [ADDRESS_WIDTH-1:0]                        mem_req_addr,
    input  logic                                            mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                           mem_rsp_data,
    input  logic                                            mem_rsp_last,
    output logic [NUM_WAYS-1:0]                             way_inval,
    output logic [NUM_WAYS-1:0]                             way_wr_en,
    output logic [calc_beat_w(calc_beats(BLOCK_SIZE, DATA_WIDTH))-1:0] way_wr_beat,
    output logic [DATA_WIDTH-1:0]                           way_wr_data,
    output logic [NUM_WAYS-1:0]                             way_tag_wr,
    output logic [ADDRESS_WIDTH-calc_offset_bits(BLOCK_SIZE)-1:0] way_tag,
    output logic                                            fill_done,
    output logic [NUM_WAYS-1:0]                             fill_way,
    output logic                                            fill_error
);

    localparam int OFFSET_BITS = calc_offset_bits(BLOCK_SIZE);
    localparam int TAG_WIDTH   = ADDRESS_WIDTH - OFFSET_BITS;
    localparam int BEATS       = calc_beats(BLOCK_SIZE, DATA_WIDTH);
    localparam int BEAT_W      = calc_beat_w(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t                state_q, state_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [NUM_WAYS-1:0]   victim_q, victim_d;
    logic                  used_rr_q, used_rr_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [NUM_WAYS-1:0]   pick_way;
    logic                  pick_rr;
    logic                  rr_advance;
    logic                  rr_clear;

    victim_select #(.NUM_WAYS(NUM_WAYS)) u_victim (
        .clk         (clk),
        .reset       (reset),
        .way_valid_i (way_valid),
        .advance_i   (rr_advance),
        .clear_i     (rr_clear),
        .victim_o    (pick_way),
        .use_rr_o    (pick_rr)
    );

    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        victim_d      = victim_q;
        used_rr_d     = used_rr_q;
        beat_d        = beat_q;
        rr_advance    = 1'b0;
        rr_clear      = 1'b0;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        way_inval     = '0;
        way_wr_en     = '0;
        way_wr_beat   = '0;
        way_wr_data   = '0;
        way_tag_wr    = '0;
        way_tag       = '0;
        fill_done     = 1'b0;
        fill_way      = '0;
        fill_error    = 1'b0;

        // Outputs are held at zero for as long as reset is asserted.
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    miss_ready = !flush;
                    if (flush) begin
                        way_inval = '1;
                        rr_clear  = 1'b1;
                    end else if (miss_valid) begin
                        tag_d     = miss_tag;
                        victim_d  = pick_way;
                        used_rr_d = pick_rr;
                        way_inval = pick_way;
                        state_d   = REQ;
                    end
                end
                REQ: begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = {tag_q, {OFFSET_BITS{1'b0}}};
                    if (mem_req_ready) begin
                        beat_d  = '0;
                        state_d = FILL;
                    end
                end
                FILL: begin
                    if (mem_rsp_valid) begin
                        way_wr_en   = victim_q;
                        way_wr_beat = beat_q;
                        way_wr_data = mem_rsp_data;
                        beat_d      = beat_q + 1'b1;
                        if (mem_rsp_last && beat_q == LAST_BEAT) begin
                            state_d = COMMIT;
                        end else if (mem_rsp_last || beat_q == LAST_BEAT) begin
                            fill_error = 1'b1;
                            fill_way   = victim_q;
                            state_d    = IDLE;
                        end
                    end
                end
                COMMIT: begin
                    way_tag_wr = victim_q;
                    way_tag    = tag_q;
                    fill_done  = 1'b1;
                    fill_way   = victim_q;
                    rr_advance = used_rr_q;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            victim_q  <= '0;
            used_rr_q <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            victim_q  <= victim_d;
            used_rr_q <= used_rr_d;
            beat_q    <= beat_d;
        end
    end

endmodule

// File: tb/tb_way_fill_controller.sv
// Directed bench for way_fill_controller; written beats are checked against
// a scoreboard queue filled as response beats are driven.
module tb_way_fill_controller;

    logic        clk;
    logic        reset;
    logic        miss_valid;
    logic        miss_ready;
    logic [26:0] miss_tag;
    logic [3:0]  way_valid;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_last;
    logic [3:0]  way_inval;
    logic [3:0]  way_wr_en;
    logic [2:0]  way_wr_beat;
    logic [31:0] way_wr_data;
    logic [3:0]  way_tag_wr;
    logic [26:0] way_tag;
    logic        fill_done;
    logic [3:0]  fill_way;
    logic        fill_error;

    typedef struct {
        logic [3:0]  way;
        logic [2:0]  beat;
        logic [31:0] data;
    } beat_t;

    beat_t sb_q[$];
    int    total = 0;
    int    bad   = 0;

    way_fill_controller dut (
        .clk           (clk),
        .reset         (reset),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_tag      (miss_tag),
        .way_valid     (way_valid),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_last  (mem_rsp_last),
        .way_inval     (way_inval),
        .way_wr_en     (way_wr_en),
        .way_wr_beat   (way_wr_beat),
        .way_wr_data   (way_wr_data),
        .way_tag_wr    (way_tag_wr),
        .way_tag       (way_tag),
        .fill_done     (fill_done),
        .fill_way      (fill_way),
        .fill_error    (fill_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every data write the DUT makes must match the next queued beat.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && |way_wr_en) begin
            if (sb_q.size() == 0) begin
                check("wr_unexpected", 64'(way_wr_en), 64'h0);
            end else begin
                e = sb_q.pop_front();
                check("wr_way", 64'(way_wr_en), 64'(e.way));
                check("wr_beat", 64'(way_wr_beat), 64'(e.beat));
                check("wr_data", 64'(way_wr_data), 64'(e.data));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [26:0] tag, input logic [3:0] valid,
                          input logic [3:0] exp_way);
        miss_valid = 1'b1;
        miss_tag   = tag;
        way_valid  = valid;
        @(negedge clk);
        check("accept_ready", 64'(miss_ready), 64'h1);
        check("accept_inval", 64'(way_inval), 64'(exp_way));
        next_cycle();
        miss_valid = 1'b0;
    endtask

    task automatic request(input logic [26:0] tag, input int stall);
        for (int i = 0; i < stall; i++) begin
            mem_req_ready = 1'b0;
            @(negedge clk);
            check("req_stall_valid", 64'(mem_req_valid), 64'h1);
            check("req_stall_addr", 64'(mem_req_addr), 64'({tag, 5'b0}));
            check("req_stall_nowr", 64'(way_wr_en), 64'h0);
            next_cycle();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("req_valid", 64'(mem_req_valid), 64'h1);
        check("req_addr", 64'(mem_req_addr), 64'({tag, 5'b0}));
        next_cycle();
        mem_req_ready = 1'b0;
    endtask

    // Drives nbeats beats, with last on beat last_at (-1 for never).
    task automatic send_beats(input logic [3:0] way, input int nbeats, input int last_at,
                              input bit good);
        beat_t e;
        for (int i = 0; i < nbeats; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = $urandom;
            mem_rsp_last  = (i == last_at);
            e.way  = way;
            e.beat = 3'(i);
            e.data = mem_rsp_data;
            sb_q.push_back(e);
            @(negedge clk);
            if (i == nbeats - 1) begin
                check("final_err", 64'(fill_error), 64'(!good));
                check("final_way", 64'(fill_way), good ? 64'h0 : 64'(way));
                check("final_tagwr", 64'(way_tag_wr), 64'h0);
            end
            next_cycle();
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;
    endtask

    task automatic run_fill(input logic [26:0] tag, input logic [3:0] valid,
                            input logic [3:0] exp_way, input int stall,
                            input int nbeats, input int last_at, input bit good);
        accept(tag, valid, exp_way);
        request(tag, stall);
        send_beats(exp_way, nbeats, last_at, good);
        if (good) begin
            @(negedge clk);
            check("commit_tagwr", 64'(way_tag_wr), 64'(exp_way));
            check("commit_tag", 64'(way_tag), 64'(tag));
            check("commit_done", 64'(fill_done), 64'h1);
            check("commit_way", 64'(fill_way), 64'(exp_way));
            next_cycle();
        end
        @(negedge clk);
        check("idle_ready", 64'(miss_ready), 64'h1);
        check("idle_no_tagwr", 64'(way_tag_wr), 64'h0);
        check("idle_no_done", 64'(fill_done), 64'h0);
        next_cycle();
    endtask

    initial begin
        reset         = 1'b1;
        miss_valid    = 1'b0;
        miss_tag      = '0;
        way_valid     = '0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_last  = 1'b0;
        #2;
        check("rst_ready", 64'(miss_ready), 64'h0);
        check("rst_inval", 64'(way_inval), 64'h0);
        check("rst_reqv", 64'(mem_req_valid), 64'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(miss_ready), 64'h1);
        next_cycle();

        // All ways invalid: tag 0x1234 fills way 0 at address 0x24680.
        run_fill(27'h1234, 4'b0000, 4'b0001, 0, 8, 7, 1'b1);
        check("addr_literal", 64'({27'h1234, 5'b0}), 64'h24680);

        // Round robin over full set, lowest invalid way takes priority without advancing.
        run_fill(27'h0a1, 4'b1111, 4'b0001, 0, 8, 7, 1'b1);
        run_fill(27'h0a2, 4'b1111, 4'b0010, 0, 8, 7, 1'b1);
        run_fill(27'h0a3, 4'b1011, 4'b0100, 0, 8, 7, 1'b1);
        run_fill(27'h0a4, 4'b1111, 4'b0100, 0, 8, 7, 1'b1);
        run_fill(27'h0a5, 4'b1111, 4'b1000, 0, 8, 7, 1'b1);
        run_fill(27'h0a6, 4'b1111, 4'b0001, 0, 8, 7, 1'b1);

        // Early last on beat 5, then a missing last on beat 7.
        run_fill(27'h5555, 4'b0011, 4'b0100, 0, 6, 5, 1'b0);
        run_fill(27'h6666, 4'b0001, 4'b0010, 2, 8, -1, 1'b0);

        // Flush wins over a concurrent miss and clears rr (currently 1).
        flush      = 1'b1;
        miss_valid = 1'b1;
        miss_tag   = 27'h777;
        way_valid  = 4'b1111;
        @(negedge clk);
        check("flush_inval", 64'(way_inval), 64'hf);
        check("flush_ready", 64'(miss_ready), 64'h0);
        next_cycle();
        flush = 1'b0;
        run_fill(27'h777, 4'b1111, 4'b0001, 0, 8, 7, 1'b1);

        // Reset during beat 3 after a 10-cycle request stall.
        accept(27'h4242, 4'b0000, 4'b0001);
        request(27'h4242, 10);
        send_beats(4'b0001, 3, -1, 1'b1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hdead_beef;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_wr", 64'(way_wr_en), 64'h0);
        check("async_rst_ready", 64'(miss_ready), 64'h0);
        check("async_rst_err", 64'(fill_error), 64'h0);
        mem_rsp_valid = 1'b0;
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_rst_ready", 64'(miss_ready), 64'h1);
            check("after_rst_tagwr", 64'(way_tag_wr), 64'h0);
            check("after_rst_reqv", 64'(mem_req_valid), 64'h0);
            next_cycle();
        end

        check("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
